serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 32 +++
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Brief    : start/busy/done operand and result bundle for serial_adder.
//            The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial adder, one full-adder slice per clock, registered
//            carry. Optional subtract via SERIAL_ADDER_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    serial_adder_if.slave  bus
);
    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_done;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_s;
    logic               w_carry;
    logic [WIDTH-1:0]   w_res_next;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and force the initial carry to 1.
    assign w_b_in = bus.sub ? ~bus.b : bus.b;
    assign w_c_in = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_b_in = bus.b;
    assign w_c_in = bus.cin;
`endif

    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_carry    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    // New sum bit enters at the MSB; after WIDTH steps bit 0 holds the LSB.
    assign w_res_next = WIDTH'({w_s, r_res} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_a   <= bus.a;
                r_b   <= w_b_in;
                r_c   <= w_c_in;
                r_cnt <= '0;
                r_res <= '0;
            end else if (w_step) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_c   <= w_carry;
                r_cnt <= r_cnt + 1'b1;
                r_res <= w_res_next;
            end
            // r_c here is the carry into the MSB slice.
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_carry;
                r_ovf  <= r_c ^ w_carry;
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Directed self-checking bench for serial_adder (WIDTH=8 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic sub8 = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

`ifdef SERIAL_ADDER_SUB_EN
    assign if8.sub = sub8;
    assign if1.sub = 1'b0;
`endif

    serial_adder #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Transaction-level model of the 8-bit instance.
    logic         m_valid = 1'b0;
    logic         m_busy, m_done, m_cout, m_ovf;
    logic [W-1:0] m_sum;
    logic [W-1:0] p_sum;
    logic         p_cout, p_ovf;
    int           m_left;

    initial begin
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b1;
                m_busy  = 1'b0;
                m_done  = 1'b0;
                m_sum   = '0;
                m_cout  = 1'b0;
                m_ovf   = 1'b0;
                m_left  = 0;
            end else if (m_valid) begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_sum  = p_sum;
                        m_cout = p_cout;
                        m_ovf  = p_ovf;
                    end
                end else if (if8.start) begin
                    bb     = sub8 ? ~if8.b : if8.b;
                    cc     = sub8 ? 1'b1 : if8.cin;
                    full   = {1'b0, if8.a} + {1'b0, bb} + {{W{1'b0}}, cc};
                    p_sum  = full[W-1:0];
                    p_cout = full[W];
                    p_ovf  = (if8.a[W-1] == bb[W-1]) && (p_sum[W-1] != if8.a[W-1]);
                    m_busy = 1'b1;
                    m_left = W;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                chk("mdl_busy", if8.busy, m_busy);
                chk("mdl_done", if8.done, m_done);
                chk("mdl_sum",  if8.sum,  m_sum);
                chk("mdl_cout", if8.cout, m_cout);
                chk("mdl_ovf",  if8.ovf,  m_ovf);
            end
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!if8.done && cyc < 40);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        int cyc;
        if8.a = a; if8.b = b; if8.cin = c; sub8 = s; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        sub8 = 1'b0;
        wait_done(cyc);
        chk({name, "_lat"},  cyc, 8);
        chk({name, "_sum"},  if8.sum, es);
        chk({name, "_cout"}, if8.cout, ec);
        chk({name, "_ovf"},  if8.ovf, eo);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [1:0] e1;
        rst = 1'b1;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        repeat (2) begin
            if8.start = 1'($urandom); if8.a = W'($urandom); if8.b = W'($urandom);
            if8.cin = 1'($urandom);
            tick();
        end
        rst = 1'b0; if8.start = 1'b0;
        chk("rst_busy", if8.busy, 0);
        chk("rst_done", if8.done, 0);
        chk("rst_sum",  if8.sum,  0);
        chk("rst_cout", if8.cout, 0);
        chk("rst_ovf",  if8.ovf,  0);

        run_op("add1", 8'd100, 8'd27, 1'b0, 1'b0, 8'd127, 1'b0, 1'b0);
        run_op("add2", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run_op("ovf1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("ovf2", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub1", 8'd5,  8'd9,  1'b0, 1'b1, 8'hFC, 1'b0, 1'b0);
        run_op("sub2", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("ovf2b", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`endif

        // Start pulsed mid-run must be ignored.
        if8.a = 8'd10; if8.b = 8'd20; if8.cin = 1'b0; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick(); tick();
        if8.a = 8'd200; if8.b = 8'd50; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        chk("ign_busy", if8.busy, 1);
        chk("ign_hold", if8.sum, 8'h00);
        wait_done(cyc);
        chk("ign_lat", cyc, 5);
        chk("ign_sum", if8.sum, 8'd30);
        tick();
        chk("ign_idle", if8.busy, 0);

        // Start held through the done cycle launches a second operation.
        if8.a = 8'd1; if8.b = 8'd2; if8.start = 1'b1;
        tick();
        if8.a = 8'd3; if8.b = 8'd4;
        wait_done(cyc);
        chk("b2b_lat1", cyc, 8);
        chk("b2b_sum1", if8.sum, 8'd3);
        tick();
        if8.start = 1'b0;
        chk("b2b_busy", if8.busy, 1);
        wait_done(cyc);
        chk("b2b_lat2", cyc, 8);
        chk("b2b_sum2", if8.sum, 8'd7);

        // Reset four cycles into a run aborts it.
        if8.a = 8'h55; if8.b = 8'h0F; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", if8.busy, 0);
        chk("abort_done", if8.done, 0);
        chk("abort_sum",  if8.sum,  0);
        chk("abort_cout", if8.cout, 0);
        chk("abort_ovf",  if8.ovf,  0);
        seen = 0;
        repeat (10) begin
            tick();
            if (if8.done) seen++;
        end
        chk("abort_nodone", seen, 0);

        // WIDTH=1: full-adder truth table, done one cycle after start.
        for (int i = 0; i < 8; i++) begin
            if1.a = 1'(i >> 2); if1.b = 1'(i >> 1); if1.cin = 1'(i);
            e1 = 2'(i >> 2 & 1) + 2'(i >> 1 & 1) + 2'(i & 1);
            if1.start = 1'b1;
            tick();
            if1.start = 1'b0;
            chk("w1_busy", if1.busy, 1);
            tick();
            chk("w1_done", if1.done, 1);
            chk("w1_sum",  if1.sum,  e1[0]);
            chk("w1_cout", if1.cout, e1[1]);
            chk("w1_ovf",  if1.ovf,  e1[1] ^ 1'(i));
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
